// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and defaults for the memory arbiter slice: FSM state encoding,
// grant-source encoding and the default line/index widths.
// No ports (package).

package mem_arb_pkg;

  localparam int ADDR_W_DEF       = 10;
  localparam int LINE_W_DEF       = 128;
  localparam int STARVE_LIMIT_DEF = 4;

  // Arbiter FSM states
  typedef enum logic [2:0] {
    IDLE,
    WB,
    DRD,
    IRD,
    RESP
  } arbState_t;

  // Which port won the current grant; RESP uses it to pick the valid pulse
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WB,
    SRC_DRD,
    SRC_IRD
  } grantSrc_t;

endpackage

// File: rtl/mem_arb_wbuf.sv
// mem_arb_wbuf
// One-entry write-back buffer between the D-cache eviction port and the
// arbiter. Captures a line when empty, holds it until the arbiter frees it,
// and flags (sticky) any strobe that arrives while the entry is occupied.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_we            write-back strobe (one cycle, never back-pressured)
//   i_addr, i_line  write-back line index and data
//   i_free          entry has been written to memory this cycle
//   o_pending       entry full, or a strobe is being captured right now
//   o_addr, o_line  pending entry (bypasses the incoming strobe when empty)
//   o_ovf           sticky overflow flag

module mem_arb_wbuf
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_line,
  input  logic              i_free,
  output logic              o_pending,
  output logic [ADDR_W-1:0] o_addr,
  output logic [LINE_W-1:0] o_line,
  output logic              o_ovf
);

  logic              r_full;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_line;
  logic              r_ovf;

  // Capture only into an empty entry; a strobe against a full entry is lost
  // and remembered in the overflow flag. Free and capture never coincide
  // because free only happens while the entry is full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full <= 1'b0;
      r_addr <= '0;
      r_line <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (i_free) begin
        r_full <= 1'b0;
      end
      if (i_we && !r_full) begin
        r_full <= 1'b1;
        r_addr <= i_addr;
        r_line <= i_line;
      end
      if (i_we && r_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Exposing the incoming strobe lets the arbiter grant the write-back in the
  // same cycle it arrives, so a same-cycle refill of that index cannot win.
  assign o_pending = r_full | i_we;
  assign o_addr    = r_full ? r_addr : i_addr;
  assign o_line    = r_full ? r_line : i_line;
  assign o_ovf     = r_ovf;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port line memory between I-cache refill, D-cache refill
// and D-cache write-back. One memory transaction at a time, fixed priority
// WB > D-read > I-read.
// Optional feature macro: ARB_STARVE_GUARD_EN -- after STARVE_LIMIT D-read
// grants that beat a waiting I-read, the next grant goes to the I-side.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   Ic_mem_req/addr             I-cache line request (level) and index
//   F_mem_inst, F_mem_valid     I-line data and one-cycle valid pulse
//   Dc_mem_req/addr             D-cache refill request (level) and index
//   MEM_data_line, MEM_mem_valid D-line data and one-cycle valid pulse
//   Dc_wb_we/addr/wline         write-back strobe, index and data
//   mem_req/we/addr/wdata       memory request side
//   mem_rdata, mem_ack          memory response side
//   wb_ovf                      sticky write-back overflow

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Ic_mem_req,
  input  logic [ADDR_W-1:0] Ic_mem_addr,
  output logic [LINE_W-1:0] F_mem_inst,
  output logic              F_mem_valid,
  input  logic              Dc_mem_req,
  input  logic [ADDR_W-1:0] Dc_mem_addr,
  output logic [LINE_W-1:0] MEM_data_line,
  output logic              MEM_mem_valid,
  input  logic              Dc_wb_we,
  input  logic [ADDR_W-1:0] Dc_wb_addr,
  input  logic [LINE_W-1:0] Dc_wb_wline,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_ovf
);

  arbState_t         r_state;
  arbState_t         w_nextState;
  grantSrc_t         r_src;
  grantSrc_t         w_grant;
  logic [ADDR_W-1:0] r_memAddr;
  logic [LINE_W-1:0] r_memWdata;
  logic [LINE_W-1:0] r_fInst;
  logic [LINE_W-1:0] r_memLine;
  logic              w_wbPending;
  logic [ADDR_W-1:0] w_wbAddr;
  logic [LINE_W-1:0] w_wbLine;
  logic              w_wbFree;
  logic              w_starveHit;

  assign w_wbFree = (r_state == WB) && mem_ack;

  mem_arb_wbuf #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) u_wbuf (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_we      (Dc_wb_we),
    .i_addr    (Dc_wb_addr),
    .i_line    (Dc_wb_wline),
    .i_free    (w_wbFree),
    .o_pending (w_wbPending),
    .o_addr    (w_wbAddr),
    .o_line    (w_wbLine),
    .o_ovf     (wb_ovf)
  );

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] r_starveCnt;

  assign w_starveHit = Ic_mem_req && (r_starveCnt >= 3'(STARVE_LIMIT));

  // Counts D-read grants that overtook a waiting I-read; saturates so a long
  // D burst cannot wrap back below the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starveCnt <= '0;
    end else if (!Ic_mem_req || (w_grant == SRC_IRD)) begin
      r_starveCnt <= '0;
    end else if ((w_grant == SRC_DRD) && (r_starveCnt != 3'd7)) begin
      r_starveCnt <= r_starveCnt + 3'd1;
    end
  end
`else
  assign w_starveHit = 1'b0;
`endif

  // Next-state and grant selection. A withdrawn request only matters in IDLE;
  // once granted, a transaction runs to its ack.
  always_comb begin
    w_nextState = r_state;
    w_grant     = SRC_NONE;
    case (r_state)
      IDLE: begin
        if (w_wbPending) begin
          w_nextState = WB;
          w_grant     = SRC_WB;
        end else if (w_starveHit) begin
          w_nextState = IRD;
          w_grant     = SRC_IRD;
        end else if (Dc_mem_req) begin
          w_nextState = DRD;
          w_grant     = SRC_DRD;
        end else if (Ic_mem_req) begin
          w_nextState = IRD;
          w_grant     = SRC_IRD;
        end
      end
      WB: begin
        if (mem_ack) begin
          w_nextState = IDLE;
        end
      end
      DRD, IRD: begin
        if (mem_ack) begin
          w_nextState = RESP;
        end
      end
      RESP: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register plus the request address/data latched at grant time, which
  // keeps mem_addr/mem_wdata stable for the whole transaction and afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_src      <= SRC_NONE;
      r_memAddr  <= '0;
      r_memWdata <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_grant != SRC_NONE) begin
        r_src <= w_grant;
      end
      case (w_grant)
        SRC_WB: begin
          r_memAddr  <= w_wbAddr;
          r_memWdata <= w_wbLine;
        end
        SRC_DRD: r_memAddr <= Dc_mem_addr;
        SRC_IRD: r_memAddr <= Ic_mem_addr;
        default: ;
      endcase
    end
  end

  // Response data registers: loaded on the ack and held until the next
  // response on the same side.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fInst   <= '0;
      r_memLine <= '0;
    end else if (mem_ack) begin
      if (r_state == IRD) begin
        r_fInst <= mem_rdata;
      end
      if (r_state == DRD) begin
        r_memLine <= mem_rdata;
      end
    end
  end

  assign mem_req       = (r_state == WB) || (r_state == DRD) || (r_state == IRD);
  assign mem_we        = (r_state == WB);
  assign mem_addr      = r_memAddr;
  assign mem_wdata     = r_memWdata;
  assign F_mem_inst    = r_fInst;
  assign MEM_data_line = r_memLine;
  assign F_mem_valid   = (r_state == RESP) && (r_src == SRC_IRD);
  assign MEM_mem_valid = (r_state == RESP) && (r_src == SRC_DRD);

endmodule
